d_shreg_univ: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit universal register built from enabled D flip-flops.
- Modes: hold, parallel load, logical shift left/right, rotate left/right, clear.
- Shift counter with one-cycle DONE pulse, so the block can serve directly as a parallel-to-serial / serial-to-parallel converter in datapath experiments.

---
 rtl/d_shreg_pkg.sv | 18 +
 rtl/d_ff_en.sv | 21 ++
 rtl/d_shreg_univ.sv | 93 +++++++++
 tb/tb_d_shreg_univ.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/d_shreg_pkg.sv
// d_shreg_pkg: mode encodings and small helpers shared by the universal
// shift register and its testbench.
package d_shreg_pkg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  // True for the four modes that advance the shift counter.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == M_SHL) || (m == M_SHR) || (m == M_ROL) || (m == M_ROR);
  endfunction

endpackage

// File: rtl/d_ff_en.sv
// d_ff_en: one-bit D flip-flop with synchronous active-high reset and
// clock enable.
//   C  - clock (rising edge)
//   R  - synchronous reset, forces Q to 0, overrides CE
//   CE - enable; 0 holds Q
//   D  - data in
//   Q  - registered data out
module d_ff_en (
  input  logic C,
  input  logic R,
  input  logic CE,
  input  logic D,
  output logic Q
);

  always_ff @(posedge C) begin
    if (R)       Q <= 1'b0;
    else if (CE) Q <= D;
  end

endmodule

// File: rtl/d_shreg_univ.sv
// d_shreg_univ: WIDTH-bit universal register (hold / load / shift / rotate /
// clear) with a saturating shift counter and a one-cycle DONE pulse when the
// WIDTH-th shift since the last load/clear completes.
//   C    - clock, rising edge
//   R    - synchronous active-high reset (Q, CNT, DONE -> 0)
//   CE   - clock enable; 0 holds Q and CNT, DONE reads 0
//   M    - mode select, see d_shreg_pkg
//   D    - parallel load data
//   SIL  - serial in for shift left (enters bit 0)
//   SIR  - serial in for shift right (enters bit WIDTH-1)
//   Q    - register contents
//   SOL  - Q[WIDTH-1]
//   SOR  - Q[0]
//   CNT  - shifts since last load/clear, saturates at WIDTH
//   DONE - registered pulse on the CNT WIDTH-1 -> WIDTH transition
module d_shreg_univ
  import d_shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [2:0]       M,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic [CW-1:0]    CNT,
  output logic             DONE
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // Data register: one enabled flop per bit. HOLD modes feed q_q back, so the
  // per-bit enable only needs CE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_ff_en u_ff (
      .C  (C),
      .R  (R),
      .CE (CE),
      .D  (q_d[i]),
      .Q  (q_q[i])
    );
  end

  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (CE) begin
      case (M)
        M_LOAD: begin q_d = D;  cnt_d = '0; end
        M_SHL:  q_d = {q_q[WIDTH-2:0], SIL};
        M_SHR:  q_d = {SIR, q_q[WIDTH-1:1]};
        M_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        M_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        M_CLR:  begin q_d = '0; cnt_d = '0; end
        default: ; // HOLD and reserved 111
      endcase
      if (is_shift_mode(M)) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Pulse only on the edge that reaches WIDTH, not while saturated.
        done_d = (cnt_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Q    = q_q;
  assign SOL  = q_q[WIDTH-1];
  assign SOR  = q_q[0];
  assign CNT  = cnt_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_d_shreg_univ.sv
module tb_d_shreg_univ;
  import d_shreg_pkg::*;

  logic       C = 1'b0;
  logic       R, CE, SIL, SIR;
  logic [2:0] M;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [31:0] d32;
  logic [7:0]  q8;  logic [3:0] cnt8;  logic sol8, sor8, done8;
  logic [1:0]  q2;  logic [1:0] cnt2;  logic sol2, sor2, done2;
  logic [31:0] q32; logic [5:0] cnt32; logic sol32, sor32, done32;

  always #5 C = ~C;

  d_shreg_univ #(.WIDTH(8)) u_w8 (
    .C(C), .R(R), .CE(CE), .M(M), .D(d8), .SIL(SIL), .SIR(SIR),
    .Q(q8), .SOL(sol8), .SOR(sor8), .CNT(cnt8), .DONE(done8));
  d_shreg_univ #(.WIDTH(2)) u_w2 (
    .C(C), .R(R), .CE(CE), .M(M), .D(d2), .SIL(SIL), .SIR(SIR),
    .Q(q2), .SOL(sol2), .SOR(sor2), .CNT(cnt2), .DONE(done2));
  d_shreg_univ #(.WIDTH(32)) u_w32 (
    .C(C), .R(R), .CE(CE), .M(M), .D(d32), .SIL(SIL), .SIR(SIR),
    .Q(q32), .SOL(sol32), .SOR(sor32), .CNT(cnt32), .DONE(done32));

  typedef struct {
    logic       r, ce;
    logic [2:0] m;
    logic [7:0] d;
    logic       si;       // drives both SIL and SIR
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];
  int   nchk = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge C); #1;
  endtask

  function automatic vec_t v(input logic r, input logic ce, input logic [2:0] m,
                             input logic [7:0] d, input logic si, input logic [7:0] q,
                             input logic [3:0] cnt, input logic done);
    vec_t t;
    t.r = r; t.ce = ce; t.m = m; t.d = d; t.si = si;
    t.exp_q = q; t.exp_cnt = cnt; t.exp_done = done;
    return t;
  endfunction

  initial begin
    logic [31:0] ld32, exp32;
    R = 1'b1; CE = 1'b0; M = M_HOLD; SIL = 1'b0; SIR = 1'b0;
    d8 = '0; d2 = '0; d32 = '0;

    // reset, load, serialise A5 with SIL=0
    vecs.push_back(v(1,0,M_HOLD,8'h00,0, 8'h00,0,0));
    vecs.push_back(v(1,1,M_LOAD,8'h3C,0, 8'h00,0,0));
    vecs.push_back(v(0,1,M_LOAD,8'hA5,0, 8'hA5,0,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h4A,1,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h94,2,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h28,3,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h50,4,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'hA0,5,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h40,6,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h80,7,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h00,8,1));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h00,8,0));
    // deserialise 1,1,0,0,1,0,1,1 via SHR
    vecs.push_back(v(0,1,M_CLR, 8'h00,0, 8'h00,0,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,1, 8'h80,1,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,1, 8'hC0,2,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h60,3,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h30,4,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,1, 8'h98,5,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h4C,6,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,1, 8'hA6,7,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,1, 8'hD3,8,1));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h69,8,0));
    vecs.push_back(v(0,1,3'b111,8'hFF,1, 8'h69,8,0));
    vecs.push_back(v(0,1,M_HOLD,8'hFF,1, 8'h69,8,0));
    // rotates with CE gaps
    vecs.push_back(v(0,1,M_LOAD,8'h81,0, 8'h81,0,0));
    vecs.push_back(v(0,1,M_ROL, 8'h00,0, 8'h03,1,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h81,2,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'hC0,3,0));
    vecs.push_back(v(0,0,M_ROR, 8'h00,0, 8'hC0,3,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h60,4,0));
    vecs.push_back(v(0,0,M_LOAD,8'hFF,0, 8'h60,4,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h30,5,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h18,6,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h0C,7,0));
    vecs.push_back(v(0,0,M_ROR, 8'h00,0, 8'h0C,7,0));
    vecs.push_back(v(0,1,M_ROR, 8'h00,0, 8'h06,8,1));
    // priority: reset beats load; load beats the would-be 8th shift
    vecs.push_back(v(1,1,M_LOAD,8'hFF,0, 8'h00,0,0));
    vecs.push_back(v(0,1,M_LOAD,8'hFF,0, 8'hFF,0,0));
    for (int k = 1; k <= 7; k++)
      vecs.push_back(v(0,1,M_SHL,8'h00,1, 8'hFF,4'(k),0));
    vecs.push_back(v(0,1,M_LOAD,8'h5A,0, 8'h5A,0,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'hB4,1,0));
    // reset mid-shift aborts, no DONE afterwards
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h5A,2,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h2D,3,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h16,4,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h0B,5,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h05,6,0));
    vecs.push_back(v(0,1,M_SHR, 8'h00,0, 8'h02,7,0));
    vecs.push_back(v(1,1,M_SHR, 8'h00,0, 8'h00,0,0));
    vecs.push_back(v(0,1,M_SHL, 8'h00,0, 8'h00,1,0));

    foreach (vecs[i]) begin
      R = vecs[i].r; CE = vecs[i].ce; M = vecs[i].m; d8 = vecs[i].d;
      SIL = vecs[i].si; SIR = vecs[i].si;
      step();
      chk($sformatf("v%0d_q", i),    32'(q8),    32'(vecs[i].exp_q));
      chk($sformatf("v%0d_cnt", i),  32'(cnt8),  32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d_done", i), 32'(done8), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_sol", i),  32'(sol8),  32'(vecs[i].exp_q[7]));
      chk($sformatf("v%0d_sor", i),  32'(sor8),  32'(vecs[i].exp_q[0]));
    end

    // WIDTH=2: load 10, shift in ones, saturate at 2
    R = 1; CE = 1; M = M_HOLD; step();
    R = 0; M = M_LOAD; d2 = 2'b10; step();
    chk("w2_load_q", 32'(q2), 32'h2);
    chk("w2_sol0", 32'(sol2), 32'h1);
    M = M_SHL; SIL = 1; step();
    chk("w2_s1_q", 32'(q2), 32'h1); chk("w2_s1_cnt", 32'(cnt2), 32'd1); chk("w2_s1_done", 32'(done2), 0);
    chk("w2_sol1", 32'(sol2), 32'h0);
    step();
    chk("w2_s2_q", 32'(q2), 32'h3); chk("w2_s2_cnt", 32'(cnt2), 32'd2); chk("w2_s2_done", 32'(done2), 1);
    step();
    chk("w2_s3_q", 32'(q2), 32'h3); chk("w2_s3_cnt", 32'(cnt2), 32'd2); chk("w2_s3_done", 32'(done2), 0);

    // WIDTH=32: serialise a pattern, 33 shifts
    ld32 = 32'hA5A5_0F0F;
    R = 1; M = M_HOLD; step();
    R = 0; M = M_LOAD; d32 = ld32; step();
    chk("w32_load_q", q32, ld32); chk("w32_load_cnt", 32'(cnt32), 0);
    M = M_SHL; SIL = 0;
    for (int k = 1; k <= 33; k++) begin
      chk($sformatf("w32_sol_%0d", k), 32'(sol32), (k > 32) ? 32'd0 : 32'(ld32[32-k]));
      step();
      exp32 = (k >= 32) ? 32'h0 : (ld32 << k);
      chk($sformatf("w32_q_%0d", k), q32, exp32);
      chk($sformatf("w32_cnt_%0d", k), 32'(cnt32), (k > 32) ? 32'd32 : 32'(k));
      chk($sformatf("w32_done_%0d", k), 32'(done32), (k == 32) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
